// File: rtl/or1k_wb_stage_cappuccino.sv
// Writeback stage of the cappuccino pipeline: result select, big-endian load alignment and GPR write pulse.
// Optional macro OR1K_WB_LOAD_ERR_SQUASH_EN: squash the GPR write of a load that completes with a bus error.
module or1k_wb_stage_cappuccino #(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int OPTION_RF_ADDR_WIDTH = 5
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            padv_ctrl_i,
    input  logic                            pipeline_flush_i,
    input  logic                            ctrl_valid_i,
    input  logic                            ctrl_rf_wb_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0] ctrl_rfd_adr_i,
    input  logic                            ctrl_op_lsu_load_i,
    input  logic                            ctrl_op_mfspr_i,
    input  logic                            ctrl_op_jal_i,
    input  logic [1:0]                      ctrl_lsu_length_i,
    input  logic                            ctrl_lsu_zext_i,
    input  logic [1:0]                      ctrl_lsu_adr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] ctrl_alu_result_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] ctrl_pc_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] mfspr_dat_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] lsu_ldat_i,
    input  logic                            lsu_valid_i,
    input  logic                            lsu_err_i,
    output logic                            wb_rf_wb_o,
    output logic [OPTION_RF_ADDR_WIDTH-1:0] wb_rfd_adr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] result_o,
    output logic                            wb_busy_o,
    output logic                            lsu_err_o
);

    localparam int DW = OPTION_OPERAND_WIDTH;
    localparam int AW = OPTION_RF_ADDR_WIDTH;

    typedef enum logic [0:0] {
        IDLE,
        LOAD_WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   ld_rfd_adr_q, ld_rfd_adr_d;
    logic            ld_rf_wb_q, ld_rf_wb_d;
    logic [1:0]      ld_len_q, ld_len_d;
    logic            ld_zext_q, ld_zext_d;
    logic [1:0]      ld_adr_q, ld_adr_d;
    logic            wb_q, wb_d;
    logic [AW-1:0]   wb_adr_q, wb_adr_d;
    logic [DW-1:0]   result_q, result_d;
    logic            err_q, err_d;

    logic            capture;
    logic            ld_err;
    logic [DW-1:0]   pc_plus8;
    logic [DW-1:0]   live_result;
    logic [DW-1:0]   pend_result;

    // Big-endian: the lowest byte address lives in the most significant lane.
    function automatic logic [31:0] align_load(input logic [31:0] dat,
                                               input logic [1:0]  len,
                                               input logic        zext,
                                               input logic [1:0]  adr);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (adr)
            2'd0:    b = dat[31:24];
            2'd1:    b = dat[23:16];
            2'd2:    b = dat[15:8];
            default: b = dat[7:0];
        endcase
        h = adr[1] ? dat[15:0] : dat[31:16];
        case (len)
            2'b00:   r = zext ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   r = zext ? {16'd0, h} : {{16{h[15]}}, h};
            default: r = dat;
        endcase
        return r;
    endfunction

    assign capture  = padv_ctrl_i & ctrl_valid_i & ~pipeline_flush_i;
    assign pc_plus8 = ctrl_pc_i + DW'(8);

`ifdef OR1K_WB_LOAD_ERR_SQUASH_EN
    assign ld_err    = lsu_err_i;
    assign lsu_err_o = err_q;
`else
    logic unused_lsu_err;
    assign unused_lsu_err = lsu_err_i;
    assign ld_err         = 1'b0;
    assign lsu_err_o      = 1'b0;
`endif

    always_comb begin
        live_result = ctrl_alu_result_i;
        if (ctrl_op_lsu_load_i)
            live_result = align_load(lsu_ldat_i, ctrl_lsu_length_i, ctrl_lsu_zext_i, ctrl_lsu_adr_i);
        else if (ctrl_op_mfspr_i)
            live_result = mfspr_dat_i;
        else if (ctrl_op_jal_i)
            live_result = pc_plus8;
    end

    assign pend_result = align_load(lsu_ldat_i, ld_len_q, ld_zext_q, ld_adr_q);

    always_comb begin
        state_d      = state_q;
        ld_rfd_adr_d = ld_rfd_adr_q;
        ld_rf_wb_d   = ld_rf_wb_q;
        ld_len_d     = ld_len_q;
        ld_zext_d    = ld_zext_q;
        ld_adr_d     = ld_adr_q;
        wb_d         = 1'b0;
        wb_adr_d     = wb_adr_q;
        result_d     = result_q;
        err_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (capture) begin
                    if (ctrl_op_lsu_load_i && !lsu_valid_i) begin
                        ld_rfd_adr_d = ctrl_rfd_adr_i;
                        ld_rf_wb_d   = ctrl_rf_wb_i;
                        ld_len_d     = ctrl_lsu_length_i;
                        ld_zext_d    = ctrl_lsu_zext_i;
                        ld_adr_d     = ctrl_lsu_adr_i;
                        state_d      = LOAD_WAIT;
                    end else if (ctrl_op_lsu_load_i && ld_err) begin
                        err_d = 1'b1;
                    end else if (ctrl_rf_wb_i) begin
                        wb_d     = 1'b1;
                        wb_adr_d = ctrl_rfd_adr_i;
                        result_d = live_result;
                    end
                end
            end
            LOAD_WAIT: begin
                // padv_ctrl_i here is a protocol violation and is deliberately not looked at.
                if (lsu_valid_i) begin
                    state_d = IDLE;
                    if (ld_err) begin
                        err_d = 1'b1;
                    end else if (ld_rf_wb_q) begin
                        wb_d     = 1'b1;
                        wb_adr_d = ld_rfd_adr_q;
                        result_d = pend_result;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (pipeline_flush_i) begin
            state_d  = IDLE;
            wb_d     = 1'b0;
            err_d    = 1'b0;
            wb_adr_d = wb_adr_q;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ld_rfd_adr_q <= '0;
            ld_rf_wb_q   <= 1'b0;
            ld_len_q     <= 2'b00;
            ld_zext_q    <= 1'b0;
            ld_adr_q     <= 2'b00;
            wb_q         <= 1'b0;
            wb_adr_q     <= '0;
            result_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            ld_rfd_adr_q <= ld_rfd_adr_d;
            ld_rf_wb_q   <= ld_rf_wb_d;
            ld_len_q     <= ld_len_d;
            ld_zext_q    <= ld_zext_d;
            ld_adr_q     <= ld_adr_d;
            wb_q         <= wb_d;
            wb_adr_q     <= wb_adr_d;
            result_q     <= result_d;
            err_q        <= err_d;
        end
    end

    assign wb_rf_wb_o   = wb_q;
    assign wb_rfd_adr_o = wb_adr_q;
    assign result_o     = result_q;
    assign wb_busy_o    = (state_q == LOAD_WAIT);

endmodule

// File: tb/tb_or1k_wb_stage_cappuccino.sv
// Scoreboard bench for or1k_wb_stage_cappuccino: directed stimulus pushes expected writes, a monitor checks them.
module tb_or1k_wb_stage_cappuccino;

    logic        clk = 1'b0;
    logic        rst;
    logic        padv_ctrl_i, pipeline_flush_i, ctrl_valid_i, ctrl_rf_wb_i;
    logic [4:0]  ctrl_rfd_adr_i;
    logic        ctrl_op_lsu_load_i, ctrl_op_mfspr_i, ctrl_op_jal_i;
    logic [1:0]  ctrl_lsu_length_i;
    logic        ctrl_lsu_zext_i;
    logic [1:0]  ctrl_lsu_adr_i;
    logic [31:0] ctrl_alu_result_i, ctrl_pc_i, mfspr_dat_i, lsu_ldat_i;
    logic        lsu_valid_i, lsu_err_i;
    logic        wb_rf_wb_o;
    logic [4:0]  wb_rfd_adr_o;
    logic [31:0] result_o;
    logic        wb_busy_o, lsu_err_o;

    typedef struct {
        logic [4:0]  adr;
        logic [31:0] data;
    } wb_exp_t;

    wb_exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

`ifdef OR1K_WB_LOAD_ERR_SQUASH_EN
    localparam bit SQUASH = 1'b1;
`else
    localparam bit SQUASH = 1'b0;
`endif

    or1k_wb_stage_cappuccino dut (
        .clk                (clk),
        .rst                (rst),
        .padv_ctrl_i        (padv_ctrl_i),
        .pipeline_flush_i   (pipeline_flush_i),
        .ctrl_valid_i       (ctrl_valid_i),
        .ctrl_rf_wb_i       (ctrl_rf_wb_i),
        .ctrl_rfd_adr_i     (ctrl_rfd_adr_i),
        .ctrl_op_lsu_load_i (ctrl_op_lsu_load_i),
        .ctrl_op_mfspr_i    (ctrl_op_mfspr_i),
        .ctrl_op_jal_i      (ctrl_op_jal_i),
        .ctrl_lsu_length_i  (ctrl_lsu_length_i),
        .ctrl_lsu_zext_i    (ctrl_lsu_zext_i),
        .ctrl_lsu_adr_i     (ctrl_lsu_adr_i),
        .ctrl_alu_result_i  (ctrl_alu_result_i),
        .ctrl_pc_i          (ctrl_pc_i),
        .mfspr_dat_i        (mfspr_dat_i),
        .lsu_ldat_i         (lsu_ldat_i),
        .lsu_valid_i        (lsu_valid_i),
        .lsu_err_i          (lsu_err_i),
        .wb_rf_wb_o         (wb_rf_wb_o),
        .wb_rfd_adr_o       (wb_rfd_adr_o),
        .result_o           (result_o),
        .wb_busy_o          (wb_busy_o),
        .lsu_err_o          (lsu_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && wb_rf_wb_o) begin
            $display("wb write rd=%0d data=%h", wb_rfd_adr_o, result_o);
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(wb_rfd_adr_o), 32'hFFFF_FFFF);
            end else begin
                wb_exp_t e;
                e = exp_q.pop_front();
                check("wb_adr", 32'(wb_rfd_adr_o), 32'(e.adr));
                check("wb_data", result_o, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        padv_ctrl_i = 0; pipeline_flush_i = 0; ctrl_valid_i = 0; ctrl_rf_wb_i = 0;
        ctrl_rfd_adr_i = '0; ctrl_op_lsu_load_i = 0; ctrl_op_mfspr_i = 0; ctrl_op_jal_i = 0;
        ctrl_lsu_length_i = 2'b10; ctrl_lsu_zext_i = 0; ctrl_lsu_adr_i = 0;
        ctrl_alu_result_i = '0; ctrl_pc_i = '0; mfspr_dat_i = '0; lsu_ldat_i = '0;
        lsu_valid_i = 0; lsu_err_i = 0;
    endtask

    task automatic push(input logic [4:0] adr, input logic [31:0] data);
        wb_exp_t e;
        e.adr = adr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic set_op(input logic [4:0] rd, input logic rf_wb, input logic ld,
                          input logic spr, input logic jal);
        padv_ctrl_i = 1; ctrl_valid_i = 1; ctrl_rf_wb_i = rf_wb; ctrl_rfd_adr_i = rd;
        ctrl_op_lsu_load_i = ld; ctrl_op_mfspr_i = spr; ctrl_op_jal_i = jal;
    endtask

    // Non-load, or load with data in the capture cycle.
    task automatic single(input logic [4:0] rd, input logic [31:0] exp);
        push(rd, exp);
        tick();
        clr();
        check("busy_after_single", 32'(wb_busy_o), 0);
        tick();
    endtask

    // Load whose data arrives 3 cycles after capture.
    task automatic pend_load(input logic [4:0] rd, input logic [1:0] len, input logic zext,
                             input logic [1:0] adr, input logic [31:0] ldat, input logic err,
                             input logic [31:0] exp);
        set_op(rd, 1, 1, 0, 0);
        ctrl_lsu_length_i = len; ctrl_lsu_zext_i = zext; ctrl_lsu_adr_i = adr;
        tick();
        clr();
        for (int i = 0; i < 3; i++) begin
            check("busy_pending", 32'(wb_busy_o), 1);
            if (i < 2) tick();
        end
        lsu_valid_i = 1; lsu_ldat_i = ldat; lsu_err_i = err;
        if (!(err && SQUASH)) push(rd, exp);
        tick();
        clr();
        check("busy_done", 32'(wb_busy_o), 0);
        check("lsu_err_pulse", 32'(lsu_err_o), 32'(err && SQUASH));
        tick();
        check("lsu_err_clear", 32'(lsu_err_o), 0);
    endtask

    initial begin
        clr();
        rst = 1;
        tick();
        tick();
        check("rst_wb", 32'(wb_rf_wb_o), 0);
        check("rst_adr", 32'(wb_rfd_adr_o), 0);
        check("rst_result", result_o, 0);
        check("rst_busy", 32'(wb_busy_o), 0);
        check("rst_err", 32'(lsu_err_o), 0);
        rst = 0;
        tick();

        // ALU op, then result must be held with no strobe.
        set_op(5'd3, 1, 0, 0, 0); ctrl_alu_result_i = 32'h1234_5678;
        single(5'd3, 32'h1234_5678);
        check("alu_strobe_low", 32'(wb_rf_wb_o), 0);
        check("alu_result_held", result_o, 32'h1234_5678);

        pend_load(5'd4, 2'b00, 0, 2'd2, 32'h1122_8544, 0, 32'hFFFF_FF85);
        pend_load(5'd5, 2'b00, 1, 2'd2, 32'h1122_8544, 0, 32'h0000_0085);
        pend_load(5'd6, 2'b01, 1, 2'd0, 32'h8001_0000, 0, 32'h0000_8001);
        pend_load(5'd8, 2'b10, 0, 2'd1, 32'hA5A5_0001, 0, 32'hA5A5_0001);

        // jal wraps mod 2^32.
        set_op(5'd9, 1, 0, 0, 1); ctrl_pc_i = 32'hFFFF_FFFC; ctrl_alu_result_i = 32'hDEAD_BEEF;
        single(5'd9, 32'h0000_0004);
        // mfspr beats jal.
        set_op(5'd10, 1, 0, 1, 1); mfspr_dat_i = 32'hCAFE_F00D; ctrl_pc_i = 32'h100;
        single(5'd10, 32'hCAFE_F00D);
        // Hit load beats mfspr: byte adr 3, sign-extend.
        set_op(5'd11, 1, 1, 1, 0); mfspr_dat_i = 32'h1111_1111;
        ctrl_lsu_length_i = 2'b00; ctrl_lsu_adr_i = 2'd3; lsu_ldat_i = 32'h1234_56F0; lsu_valid_i = 1;
        single(5'd11, 32'hFFFF_FFF0);
        // Hit half load, adr[1]=1, adr[0] ignored, sign-extend.
        set_op(5'd12, 1, 1, 0, 0);
        ctrl_lsu_length_i = 2'b01; ctrl_lsu_adr_i = 2'd3; lsu_ldat_i = 32'h1234_8000; lsu_valid_i = 1;
        single(5'd12, 32'hFFFF_8000);
        // Byte adr 1 hit, zero-extend.
        set_op(5'd13, 1, 1, 0, 0);
        ctrl_lsu_length_i = 2'b00; ctrl_lsu_zext_i = 1; ctrl_lsu_adr_i = 2'd1; lsu_ldat_i = 32'h12C4_5678; lsu_valid_i = 1;
        single(5'd13, 32'h0000_00C4);

        // No rf_wb: nothing written, result held.
        set_op(5'd14, 0, 0, 0, 0); ctrl_alu_result_i = 32'h7777_7777;
        tick(); clr(); tick();
        check("norfwb_result_held", result_o, 32'h0000_00C4);
        check("norfwb_adr_held", 32'(wb_rfd_adr_o), 32'd13);

        // Flush coincident with capture suppresses it.
        set_op(5'd15, 1, 0, 0, 0); ctrl_alu_result_i = 32'h9999_9999; pipeline_flush_i = 1;
        tick(); clr(); tick();
        check("flush_capture_held", result_o, 32'h0000_00C4);

        // Flush coincident with load data: no write, busy drops.
        set_op(5'd16, 1, 1, 0, 0); ctrl_lsu_length_i = 2'b10;
        tick(); clr();
        check("flush_busy_before", 32'(wb_busy_o), 1);
        lsu_valid_i = 1; lsu_ldat_i = 32'hBAD0_BAD0; pipeline_flush_i = 1;
        tick(); clr();
        check("flush_busy_after", 32'(wb_busy_o), 0);
        set_op(5'd7, 1, 0, 0, 0); ctrl_alu_result_i = 32'h0000_0055;
        single(5'd7, 32'h0000_0055);

        // Load with bus error.
        pend_load(5'd17, 2'b10, 0, 2'd0, 32'h0BAD_0BAD, 1, 32'h0BAD_0BAD);

        // Async reset in LOAD_WAIT discards the pending load.
        set_op(5'd18, 1, 1, 0, 0); ctrl_lsu_length_i = 2'b10;
        tick(); clr();
        tick();
        check("pre_rst_busy", 32'(wb_busy_o), 1);
        #1 rst = 1;
        #1;
        check("arst_wb", 32'(wb_rf_wb_o), 0);
        check("arst_adr", 32'(wb_rfd_adr_o), 0);
        check("arst_result", result_o, 0);
        check("arst_busy", 32'(wb_busy_o), 0);
        check("arst_err", 32'(lsu_err_o), 0);
        #2 rst = 0;
        lsu_valid_i = 1; lsu_ldat_i = 32'h4444_4444;
        tick(); clr();
        tick();
        check("post_rst_result", result_o, 0);
        check("post_rst_busy", 32'(wb_busy_o), 0);

        tick();
        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
